// File: rtl/core_pkg.sv
// Shared definitions for the core writeback path.
//   - Functional-unit indices (FU_ALU .. FU_JUMP) and their count NUM_FU.
//   - Datapath widths DATA_W (result) and RD_W (destination register index).
//   - wb_req_t: one writeback request {valid, rd, data}.
//   - next_ptr(): modulo increment used by the round-robin pointer.
package core_pkg;

    localparam int FU_ALU  = 0;
    localparam int FU_MEM  = 1;
    localparam int FU_MUL  = 2;
    localparam int FU_DIV  = 3;
    localparam int FU_JUMP = 4;
    localparam int NUM_FU  = 5;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    typedef struct packed {
        logic              valid;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Index following idx, wrapping back to 0 after n-1.
    function automatic int next_ptr(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Rotating-start priority picker.
// Scans req starting at index ptr, then ptr+1, ... with wrap-around, and
// grants the first requester found. With ptr tied to 0 this degenerates to
// plain lowest-index-wins priority.
// Ports:
//   req        in   NUM_FU  requesting slots
//   ptr        in   IDX_W   index where the scan starts
//   grant      out  NUM_FU  one-hot grant (all zero when nothing requests)
//   grant_idx  out  IDX_W   encoded index of the grant (0 when none)
module wb_rr_picker
    import core_pkg::*;
#(
    parameter int NUM_FU = core_pkg::NUM_FU,
    parameter int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_FU-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            j = (int'(ptr) + k) % NUM_FU;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter downstream of the functional units.
// Every FU finish pulse is captured into that FU's holding slot; one slot per
// cycle is presented on the writeback port and released at the end of the
// cycle in which it was presented.
// Build option: define WB_ROUND_ROBIN_EN for a rotating-priority search
// (start index moves to granted+1 after every grant); otherwise the lowest
// index always wins.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   fu_finish  per-FU one-cycle result-valid pulse
//   fu_res     packed results, FU i at [i*DATA_W +: DATA_W]
//   fu_rd      packed destination indices, FU i at [i*RD_W +: RD_W]
//   fu_hold    slot occupied and not granted this cycle; FU must not finish
//   wb_valid   a writeback is presented this cycle
//   wb_fu      index of the granted FU (0 when idle)
//   wb_rd      destination register (0 when idle)
//   wb_data    result data (0 when idle)
//   overflow   sticky: an FU finished while its slot was held
module fu_wb_arbiter
    import core_pkg::*;
#(
    parameter int NUM_FU = core_pkg::NUM_FU,
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int RD_W   = core_pkg::RD_W,
    localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_finish,
    input  logic [NUM_FU*DATA_W-1:0] fu_res,
    input  logic [NUM_FU*RD_W-1:0]   fu_rd,
    output logic [NUM_FU-1:0]        fu_hold,
    output logic                     wb_valid,
    output logic [IDX_W-1:0]         wb_fu,
    output logic [RD_W-1:0]          wb_rd,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     overflow
);

    logic [NUM_FU-1:0] slot_valid;
    logic [RD_W-1:0]   slot_rd   [NUM_FU];
    logic [DATA_W-1:0] slot_data [NUM_FU];

    logic [NUM_FU-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [NUM_FU-1:0] accept;

    wb_rr_picker #(
        .NUM_FU (NUM_FU),
        .IDX_W  (IDX_W)
    ) u_picker (
        .req       (slot_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

`ifdef WB_ROUND_ROBIN_EN
    // Start the next search just past the slot granted this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (wb_valid) begin
            rr_ptr <= IDX_W'(next_ptr(int'(grant_idx), NUM_FU));
        end
    end
`else
    assign rr_ptr = '0;
`endif

    assign fu_hold  = slot_valid & ~grant;
    // A slot being granted this cycle is free to take a new result at the
    // same edge; a held slot rejects it.
    assign accept   = fu_finish & ~fu_hold;

    assign wb_valid = |slot_valid;
    assign wb_fu    = wb_valid ? grant_idx : '0;
    assign wb_rd    = wb_valid ? slot_rd[grant_idx]   : '0;
    assign wb_data  = wb_valid ? slot_data[grant_idx] : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (rst) begin
                slot_valid[i] <= 1'b0;
            end else if (accept[i]) begin
                slot_valid[i] <= 1'b1;
            end else if (grant[i]) begin
                slot_valid[i] <= 1'b0;
            end
        end
    end

    // Slot payload carries no reset: it is only ever observed through
    // slot_valid, which the reset clears.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (accept[i]) begin
                slot_rd[i]   <= fu_rd[i*RD_W +: RD_W];
                slot_data[i] <= fu_res[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (|(fu_finish & fu_hold)) begin
            overflow <= 1'b1;
        end
    end

endmodule
